// File: rtl/power2multiplier_seq_if.sv
// Handshake bundle for the sequential power-of-two multiplier: operand request
// channel (in_*) and result channel (out_*, product, overflow).
interface power2multiplier_seq_if #(
  parameter int PRODUCT_WIDTH    = 96,
  parameter int MULTIPLIER_WIDTH = 32
);
  logic                        in_valid;
  logic                        in_ready;
  logic [PRODUCT_WIDTH-1:0]    multiplicand;
  logic [MULTIPLIER_WIDTH-1:0] multiplier;
  logic                        out_valid;
  logic                        out_ready;
  logic [PRODUCT_WIDTH-1:0]    product;
  logic                        overflow;

  modport master (
    output in_valid, multiplicand, multiplier, out_ready,
    input  in_ready, out_valid, product, overflow
  );

  modport slave (
    input  in_valid, multiplicand, multiplier, out_ready,
    output in_ready, out_valid, product, overflow
  );
endinterface

// File: rtl/power2multiplier_seq.sv
// Sequential power-of-two multiplier: product = multiplicand << floor(log2(multiplier)),
// one bit per cycle. Define POWER2MULT_SATURATE_EN to saturate on overflow instead of wrapping.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for a request, in_ready high
// ST_SHIFT | shifting p_q left while m_q still has a set bit above bit 0
// ST_DONE  | result presented with out_valid, held until out_ready
module power2multiplier_seq #(
  parameter int PRODUCT_WIDTH    = 96,
  parameter int MULTIPLIER_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  power2multiplier_seq_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]                  state_q, state_d;
  logic [PRODUCT_WIDTH-1:0]    p_q, p_d;
  logic [MULTIPLIER_WIDTH-1:0] m_q, m_d;
  logic                        ovf_q, ovf_d;
  logic                        out_valid_q, out_valid_d;
  logic                        more_shift;
  logic [PRODUCT_WIDTH-1:0]    p_shl;

  // m_q walks right until only bit 0 (or nothing) is left: that is k shifts.
  assign more_shift = |m_q[MULTIPLIER_WIDTH-1:1];
  assign p_shl      = {p_q[PRODUCT_WIDTH-2:0], 1'b0};

  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    m_d         = m_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          p_d     = (bus.multiplier == '0) ? '0 : bus.multiplicand;
          m_d     = bus.multiplier;
          ovf_d   = 1'b0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (more_shift) begin
          ovf_d = ovf_q | p_q[PRODUCT_WIDTH-1];
`ifdef POWER2MULT_SATURATE_EN
          // Once saturated the MSB stays set, so later shifts keep all ones.
          p_d   = p_q[PRODUCT_WIDTH-1] ? '1 : p_shl;
`else
          p_d   = p_shl;
`endif
          m_d   = m_q >> 1;
        end else begin
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      p_q         <= '0;
      m_q         <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      m_q         <= m_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.product   = p_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_power2multiplier_seq.sv
// Bench for power2multiplier_seq: directed literal cases, then random traffic
// checked every cycle against a latency/arithmetic model of the block.
module tb_power2multiplier_seq;
  localparam int PW = 96;
  localparam int MW = 32;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  power2multiplier_seq_if #(.PRODUCT_WIDTH(PW), .MULTIPLIER_WIDTH(MW)) bus ();

  power2multiplier_seq #(.PRODUCT_WIDTH(PW), .MULTIPLIER_WIDTH(MW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int log2_floor(input logic [MW-1:0] m);
    int k;
    k = 0;
    for (int i = 0; i < MW; i++) if (m[i]) k = i;
    return k;
  endfunction

  // Expected result straight from the arithmetic definition.
  function automatic void ref_result(input logic [PW-1:0] mc, input logic [MW-1:0] ml,
                                     output logic [PW-1:0] p, output logic o);
    logic [PW+MW-1:0] full;
    full = {{MW{1'b0}}, mc} << log2_floor(ml);
    if (ml == '0) full = '0;
    o = |full[PW+MW-1:PW];
`ifdef POWER2MULT_SATURATE_EN
    p = o ? {PW{1'b1}} : full[PW-1:0];
`else
    p = full[PW-1:0];
`endif
  endfunction

  // Model state: busy = request in flight, cnt = edges until result appears.
  bit            m_live = 0;
  bit            m_busy, m_valid, m_known;
  int            m_cnt;
  logic [PW-1:0] m_prod, m_pend_p;
  logic          m_ovf, m_pend_o;

  always @(negedge clk) begin
    if (m_live) begin
      chk("mon in_ready", PW'(bus.in_ready), PW'(!m_busy));
      chk("mon out_valid", PW'(bus.out_valid), PW'(m_valid));
      if (m_known) begin
        chk("mon product", bus.product, m_prod);
        chk("mon overflow", PW'(bus.overflow), PW'(m_ovf));
      end
    end
    if (rst) begin
      m_live = 1; m_busy = 0; m_valid = 0; m_known = 1;
      m_prod = '0; m_ovf = 1'b0;
    end else if (m_live) begin
      if (!m_busy) begin
        if (bus.in_valid) begin
          m_busy  = 1;
          m_known = 0;
          m_cnt   = log2_floor(bus.multiplier) + 1;
          ref_result(bus.multiplicand, bus.multiplier, m_pend_p, m_pend_o);
        end
      end else if (!m_valid) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_valid = 1; m_known = 1;
          m_prod  = m_pend_p; m_ovf = m_pend_o;
        end
      end else if (bus.out_ready) begin
        m_valid = 0; m_busy = 0; m_known = 0;
      end
    end
  end

  // Called at posedge+1 with the DUT idle; hold>0 applies back-pressure.
  task automatic run_op(input string nm, input logic [PW-1:0] mc, input logic [MW-1:0] ml,
                        input int hold, input logic [PW-1:0] exp_p, input logic exp_o,
                        input int exp_lat);
    int n;
    bus.in_valid     = 1'b1;
    bus.multiplicand = mc;
    bus.multiplier   = ml;
    bus.out_ready    = (hold == 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " latency"}, PW'(n), PW'(exp_lat));
    chk({nm, " product"}, bus.product, exp_p);
    chk({nm, " overflow"}, PW'(bus.overflow), PW'(exp_o));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid     = 1'b1;
      bus.multiplicand = 7;
      bus.multiplier   = 4;
      @(posedge clk); #1;
      chk({nm, " held product"}, bus.product, exp_p);
      chk({nm, " held out_valid"}, PW'(bus.out_valid), PW'(1));
      chk({nm, " held in_ready"}, PW'(bus.in_ready), PW'(0));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({nm, " out_valid drop"}, PW'(bus.out_valid), PW'(0));
    chk({nm, " in_ready back"}, PW'(bus.in_ready), PW'(1));
  endtask

  logic [PW-1:0] big_p;
  logic [PW-1:0] top_bit;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus.in_valid     = 1'b0;
    bus.out_ready    = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", PW'(bus.in_ready), PW'(1));
    chk("reset out_valid", PW'(bus.out_valid), PW'(0));
    chk("reset product", bus.product, '0);
    chk("reset overflow", PW'(bus.overflow), PW'(0));
    rst = 1'b0;

    run_op("mul8", 5, 8, 0, 40, 1'b0, 4);
    run_op("mul12", 5, 12, 0, 40, 1'b0, 4);
    run_op("mul1", 5, 1, 0, 5, 1'b0, 1);
    run_op("mul0", 5, 0, 0, 0, 1'b0, 1);
    top_bit = '0;
    top_bit[PW-1] = 1'b1;
`ifdef POWER2MULT_SATURATE_EN
    big_p = {PW{1'b1}};
`else
    big_p = '0;
`endif
    run_op("ovf", top_bit, 2, 0, big_p, 1'b1, 2);
    run_op("backpressure", 5, 8, 5, 40, 1'b0, 4);

    bus.in_valid     = 1'b1;
    bus.multiplicand = 9;
    bus.multiplier   = 32'h8000_0000;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort out_valid", PW'(bus.out_valid), PW'(0));
    chk("abort product", bus.product, '0);
    chk("abort overflow", PW'(bus.overflow), PW'(0));
    chk("abort in_ready", PW'(bus.in_ready), PW'(1));
    run_op("after abort", 3, 2, 0, 6, 1'b0, 2);

    for (int c = 0; c < 8000; c++) begin
      int sel;
      rst              = ($urandom_range(0, 599) == 0);
      bus.in_valid     = ($urandom_range(0, 2) == 0);
      bus.out_ready    = ($urandom_range(0, 1) == 1);
      bus.multiplicand = {$urandom, $urandom, $urandom};
      sel = $urandom_range(0, 9);
      if (sel == 0)      bus.multiplier = '0;
      else if (sel == 1) bus.multiplier = 1;
      else               bus.multiplier = $urandom >> $urandom_range(0, 31);
      @(posedge clk); #1;
    end
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("final idle", PW'(bus.in_ready), PW'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
